// File: rtl/ram_read_src_arbiter.sv
// Round-robin read-port arbiter for the shared feature-map RAM: latches engine requests, holds the
// winner's address vector for the whole burst, routes burst-done back and aborts hung bursts.
module ram_read_src_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned LANES   = 12,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned SRC_W   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_SRC-1:0]                i_srcEn,
  input  logic [NUM_SRC*LANES*ADDR_W-1:0]   i_addr,
  input  logic [NUM_SRC-1:0]                i_startRead,
  input  logic                              i_readDone,
  output logic [LANES*ADDR_W-1:0]           o_addr,
  output logic                              o_startRead,
  output logic [SRC_W-1:0]                  o_grantIdx,
  output logic                              o_busy,
  output logic [NUM_SRC-1:0]                o_ack,
  output logic [NUM_SRC-1:0]                o_done,
  output logic                              o_err
);

  localparam int unsigned VecW  = LANES * ADDR_W;
  localparam int unsigned WdogW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdogW-1:0] WdogMax = WdogW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [WdogW-1:0]   wdog_q, wdog_d;
  logic [VecW-1:0]    addr_q, addr_d;
  logic [SRC_W-1:0]   gidx_q, gidx_d;
  logic               start_q, start_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic [NUM_SRC-1:0] done_q, done_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] req;
  logic               win_vld;
  logic [SRC_W-1:0]   win_idx;

  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] a, input int unsigned b);
    return SRC_W'((32'(a) + b) % NUM_SRC);
  endfunction

  assign req = (pend_q | i_startRead) & i_srcEn;

  // First eligible source at or after the round-robin pointer, searching upward with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!win_vld && req[wrap_add(rr_q, k)]) begin
        win_vld = 1'b1;
        win_idx = wrap_add(rr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = req;
    rr_d    = rr_q;
    wdog_d  = wdog_q;
    addr_d  = addr_q;
    gidx_d  = gidx_q;
    start_d = 1'b0;
    ack_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d         = StIssue;
          addr_d          = i_addr[win_idx*VecW +: VecW];
          gidx_d          = win_idx;
          start_d         = 1'b1;
          ack_d[win_idx]  = 1'b1;
          pend_d[win_idx] = 1'b0;
          rr_d            = wrap_add(win_idx, 1);
        end
      end
      StIssue: begin
        state_d = StWait;
        wdog_d  = '0;
      end
      StWait: begin
        if (i_readDone) begin
          done_d[gidx_q] = 1'b1;
          state_d        = StIdle;
        end else if (TIMEOUT != 0 && wdog_q == WdogMax) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      rr_q    <= '0;
      wdog_q  <= '0;
      addr_q  <= '0;
      gidx_q  <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      wdog_q  <= wdog_d;
      addr_q  <= addr_d;
      gidx_q  <= gidx_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_addr      = addr_q;
  assign o_startRead = start_q;
  assign o_grantIdx  = gidx_q;
  assign o_busy      = (state_q != StIdle);
  assign o_ack       = ack_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_ram_read_src_arbiter.sv
// Randomized bench for ram_read_src_arbiter: a burst-level reference model queues expected pulses
// and levels; an independent monitor compares them against the DUT every cycle.
module tb_ram_read_src_arbiter;

  localparam int NumSrc  = 4;
  localparam int Lanes   = 12;
  localparam int AddrW   = 9;
  localparam int SrcW    = 2;
  localparam int Timeout = 8;
  localparam int VecW    = Lanes * AddrW;

  localparam int EvGrant = 0;
  localparam int EvDone  = 1;
  localparam int EvErr   = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NumSrc-1:0]          src_en;
  logic [NumSrc*VecW-1:0]     addr;
  logic [NumSrc-1:0]          start;
  logic                       read_done;
  logic [VecW-1:0]            o_addr;
  logic                       o_startRead;
  logic [SrcW-1:0]            o_grantIdx;
  logic                       o_busy;
  logic [NumSrc-1:0]          o_ack;
  logic [NumSrc-1:0]          o_done;
  logic                       o_err;

  always #5 clk = ~clk;

  ram_read_src_arbiter #(
    .NUM_SRC (NumSrc),
    .LANES   (Lanes),
    .ADDR_W  (AddrW),
    .SRC_W   (SrcW),
    .TIMEOUT (Timeout)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_srcEn     (src_en),
    .i_addr      (addr),
    .i_startRead (start),
    .i_readDone  (read_done),
    .o_addr      (o_addr),
    .o_startRead (o_startRead),
    .o_grantIdx  (o_grantIdx),
    .o_busy      (o_busy),
    .o_ack       (o_ack),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  typedef struct {
    int              kind;
    int              idx;
    int              cyc;
  } ev_t;

  typedef struct {
    bit              busy;
    int              gidx;
    logic [VecW-1:0] addr;
  } lvl_t;

  ev_t  ev_q[$];
  lvl_t lvl_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   hold_addr = 1'b0;

  // Reference model: cycles elapsed since the grant (0 = port free), owner, latched vector.
  logic [NumSrc-1:0] m_pend = '0;
  int                m_rr = 0;
  int                m_since = 0;
  int                m_owner = 0;
  logic [VecW-1:0]   m_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input bit ok, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endfunction

  task automatic model(input int stamp);
    logic [NumSrc-1:0] req;
    int                w;
    if (rst) begin
      m_pend  = '0;
      m_rr    = 0;
      m_since = 0;
      m_owner = 0;
      m_addr  = '0;
    end else begin
      req = (m_pend | start) & src_en;
      if (m_since == 0) begin
        if (req != '0) begin
          w = -1;
          for (int k = 0; k < NumSrc; k++)
            if (w < 0 && req[(m_rr + k) % NumSrc]) w = (m_rr + k) % NumSrc;
          req[w]  = 1'b0;
          m_rr    = (w + 1) % NumSrc;
          m_owner = w;
          m_addr  = addr[w*VecW +: VecW];
          m_since = 1;
          ev_q.push_back('{kind: EvGrant, idx: w, cyc: stamp});
        end
      end else if (m_since == 1) begin
        m_since = 2;
      end else if (read_done) begin
        ev_q.push_back('{kind: EvDone, idx: m_owner, cyc: stamp});
        m_since = 0;
      end else if (m_since - 2 == Timeout - 1) begin
        ev_q.push_back('{kind: EvErr, idx: m_owner, cyc: stamp});
        m_since = 0;
      end else begin
        m_since++;
      end
      m_pend = req;
    end
    lvl_q.push_back('{busy: (m_since != 0), gidx: m_owner, addr: m_addr});
  endtask

  task automatic step(input bit r, input logic [NumSrc-1:0] en, input logic [NumSrc-1:0] st,
                      input bit dn);
    rst       = r;
    src_en    = en;
    start     = st;
    read_done = dn;
    if (!hold_addr)
      for (int i = 0; i < NumSrc * Lanes; i++) addr[i*AddrW +: AddrW] = AddrW'($urandom);
    model(cyc + 1);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [NumSrc-1:0] en, input bit dn);
    repeat (n) step(1'b0, en, '0, dn);
  endtask

  // Answers each burst two cycles into WAIT.
  task automatic serve(input int n, input logic [NumSrc-1:0] en);
    repeat (n) step(1'b0, en, '0, m_since >= 4);
  endtask

  initial begin : monitor
    lvl_t            l;
    ev_t             e;
    bit              has_ev;
    bit              exp_start;
    bit              exp_err;
    logic [NumSrc-1:0] exp_ack;
    logic [NumSrc-1:0] exp_done;
    forever begin
      @(posedge clk);
      #1;
      if (lvl_q.size() != 0) begin
        l = lvl_q.pop_front();
        check("busy", o_busy === l.busy, 128'(o_busy), 128'(l.busy));
        check("grant_idx", o_grantIdx === SrcW'(l.gidx), 128'(o_grantIdx), 128'(l.gidx));
        check("addr", o_addr === l.addr, 128'(o_addr), 128'(l.addr));
        has_ev    = (ev_q.size() != 0) && (ev_q[0].cyc == cyc);
        exp_start = 1'b0;
        exp_err   = 1'b0;
        exp_ack   = '0;
        exp_done  = '0;
        if (has_ev) begin
          e = ev_q.pop_front();
          case (e.kind)
            EvGrant: begin exp_start = 1'b1; exp_ack[e.idx] = 1'b1; end
            EvDone:  exp_done[e.idx] = 1'b1;
            default: exp_err = 1'b1;
          endcase
        end
        if (has_ev || o_startRead !== 1'b0 || o_ack !== '0 || o_done !== '0 || o_err !== 1'b0)
        begin
          check("start_read", o_startRead === exp_start, 128'(o_startRead), 128'(exp_start));
          check("ack", o_ack === exp_ack, 128'(o_ack), 128'(exp_ack));
          check("done", o_done === exp_done, 128'(o_done), 128'(exp_done));
          check("err", o_err === exp_err, 128'(o_err), 128'(exp_err));
        end
      end
    end
  end

  initial begin : driver
    logic [NumSrc-1:0] en;
    logic [NumSrc-1:0] st;
    bit                r;
    addr = '0;
    // Reset, then a quiet port.
    repeat (3) step(1'b1, 4'hF, '0, 1'b0);
    idle(20, 4'hF, 1'b0);
    // Single request from source 1 with a recognisable vector, done four cycles after start.
    for (int i = 0; i < NumSrc * Lanes; i++) addr[i*AddrW +: AddrW] = AddrW'(i);
    for (int i = 0; i < Lanes; i++) addr[VecW + i*AddrW +: AddrW] = 9'h0BC;
    hold_addr = 1'b1;
    step(1'b0, 4'hF, 4'b0010, 1'b0);
    idle(3, 4'hF, 1'b0);
    step(1'b0, 4'hF, '0, 1'b1);
    idle(3, 4'hF, 1'b0);
    hold_addr = 1'b0;
    // Simultaneous requests, then 0 and 2 together after the pointer wraps.
    step(1'b0, 4'hF, 4'b1101, 1'b0);
    serve(25, 4'hF);
    step(1'b0, 4'hF, 4'b0101, 1'b0);
    serve(16, 4'hF);
    // Masking: disabled source ignored; pending request dropped when its enable falls.
    step(1'b0, 4'b1011, 4'b0100, 1'b0);
    idle(5, 4'b1011, 1'b0);
    step(1'b0, 4'hF, 4'b0001, 1'b0);
    step(1'b0, 4'hF, 4'b1000, 1'b1);
    step(1'b0, 4'b0111, '0, 1'b0);
    serve(10, 4'b0111);
    serve(5, 4'hF);
    // Owner re-requests while busy alongside source 1.
    step(1'b0, 4'hF, 4'b0001, 1'b0);
    step(1'b0, 4'hF, 4'b0011, 1'b0);
    serve(20, 4'hF);
    // Watchdog abort with no done, then reset mid-WAIT followed by a stray done.
    step(1'b0, 4'hF, 4'b0100, 1'b0);
    idle(15, 4'hF, 1'b0);
    step(1'b0, 4'hF, 4'b0001, 1'b0);
    idle(3, 4'hF, 1'b0);
    step(1'b1, 4'hF, '0, 1'b0);
    idle(3, 4'hF, 1'b1);
    idle(5, 4'hF, 1'b0);
    // Random traffic.
    repeat (2500) begin
      en = ($urandom_range(0, 5) == 0) ? NumSrc'($urandom) : 4'hF;
      st = '0;
      for (int s = 0; s < NumSrc; s++) st[s] = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 199) == 0);
      step(r, en, st, $urandom_range(0, 3) == 0);
    end
    idle(2, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    check("events_drained", ev_q.size() == 0, 128'(ev_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
